// File: rtl/shift_sched_if.sv
// -----------------------------------------------------------------------------
// shift_sched_if
// Requester-side handshake bundle for shift_sched: two word producers, each with
// a valid/ready pair and a WIDTH-bit parallel word.
//
// Signals
//   req0_valid_i / req1_valid_i  producer holds a word
//   req0_data_i  / req1_data_i   producer word, held stable until ready
//   req0_ready_o / req1_ready_o  word taken on this cycle's rising edge if valid
//
// Modports
//   slave  : the scheduler (consumes valid/data, drives ready)
//   master : a producer    (drives valid/data, observes ready)
// -----------------------------------------------------------------------------
interface shift_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid_i;
  logic [WIDTH-1:0] req0_data_i;
  logic             req0_ready_o;
  logic             req1_valid_i;
  logic [WIDTH-1:0] req1_data_i;
  logic             req1_ready_o;

  modport slave (
    input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
    output req0_ready_o, req1_ready_o
  );

  modport master (
    output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
    input  req0_ready_o, req1_ready_o
  );
endinterface

// File: rtl/shift_sched.sv
// -----------------------------------------------------------------------------
// shift_sched
// Round-robin scheduler and serializer for the bit-serial shift-register
// datapath. One of two requesters is granted while idle, its word is captured
// and driven MSB-first on x_o with a frame strobe, then the line is held idle
// for GAP cycles before the next grant. Frame period is WIDTH+GAP+1 cycles.
//
// Parameters
//   WIDTH  bits per frame (2..16)
//   GAP    idle cycles between frames (0..15)
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   req_if   requester handshakes (slave modport); ready is combinational
//   x_o      serial data, registered
//   frame_o  high while x_o carries a frame bit, registered
//   src_o    requester being shifted, registered, held after the frame
//   busy_o   scheduler is not idle
//   done_o   one-cycle pulse on the last bit of a frame, registered
// -----------------------------------------------------------------------------
module shift_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic         clk,
  input  logic         reset,
  shift_sched_if.slave req_if,
  output logic         x_o,
  output logic         frame_o,
  output logic         src_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_x;
  logic             r_frame;
  logic             r_src;
  logic             r_done;

  state_t           w_nxt_state;
  logic             w_nxt_last;
  logic [WIDTH-1:0] w_nxt_shreg;
  logic [CNT_W-1:0] w_nxt_bit_cnt;
  logic [GAP_W-1:0] w_nxt_gap_cnt;
  logic             w_nxt_x;
  logic             w_nxt_frame;
  logic             w_nxt_src;
  logic             w_nxt_done;

  logic             w_idle;
  logic             w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  assign w_idle  = (r_state == S_IDLE);
  assign w_grant = (req_if.req0_valid_i & req_if.req1_valid_i) ? ~r_last
                                                               : req_if.req1_valid_i;
  assign req_if.req0_ready_o = w_idle & req_if.req0_valid_i & ~w_grant;
  assign req_if.req1_ready_o = w_idle & req_if.req1_valid_i &  w_grant;
  assign w_xfer = req_if.req0_ready_o | req_if.req1_ready_o;
  assign w_data = w_grant ? req_if.req1_data_i : req_if.req0_data_i;

  // Output registers are loaded one edge ahead, so the value computed here is
  // what appears on x_o/frame_o/done_o during the following cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_nxt_state   = r_state;
    w_nxt_last    = r_last;
    w_nxt_shreg   = r_shreg;
    w_nxt_bit_cnt = r_bit_cnt;
    w_nxt_gap_cnt = r_gap_cnt;
    w_nxt_x       = 1'b0;
    w_nxt_frame   = 1'b0;
    w_nxt_src     = r_src;
    w_nxt_done    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_nxt_state   = S_SHIFT;
          w_nxt_shreg   = w_data;
          w_nxt_bit_cnt = BIT_LAST;
          w_nxt_last    = w_grant;
          w_nxt_src     = w_grant;
          w_nxt_x       = w_data[WIDTH-1];
          w_nxt_frame   = 1'b1;
        end
      end

      S_SHIFT: begin
        if (r_bit_cnt == '0) begin
          if (GAP > 0) begin
            w_nxt_state   = S_GAP;
            w_nxt_gap_cnt = GAP_LAST;
          end else begin
            w_nxt_state   = S_IDLE;
          end
        end else begin
          // Bit WIDTH-2 of the current register is the MSB after this shift.
          w_nxt_shreg   = r_shreg << 1;
          w_nxt_x       = r_shreg[WIDTH-2];
          w_nxt_frame   = 1'b1;
          w_nxt_done    = (r_bit_cnt == CNT_W'(1));
          w_nxt_bit_cnt = r_bit_cnt - 1'b1;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_nxt_state   = S_IDLE;
        end else begin
          w_nxt_gap_cnt = r_gap_cnt - 1'b1;
        end
      end

      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Reset wins over a transfer in the same cycle, so no word is taken then.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_x       <= 1'b0;
      r_frame   <= 1'b0;
      r_src     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_last    <= w_nxt_last;
      r_shreg   <= w_nxt_shreg;
      r_bit_cnt <= w_nxt_bit_cnt;
      r_gap_cnt <= w_nxt_gap_cnt;
      r_x       <= w_nxt_x;
      r_frame   <= w_nxt_frame;
      r_src     <= w_nxt_src;
      r_done    <= w_nxt_done;
    end
  end

  assign x_o     = r_x;
  assign frame_o = r_frame;
  assign src_o   = r_src;
  assign done_o  = r_done;
  assign busy_o  = ~w_idle;

endmodule

// File: tb/tb_shift_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_sched
// Directed bench for shift_sched. dut_a is the WIDTH=4, GAP=1 build; dut_b is
// the WIDTH=4, GAP=0 build. Inputs change 2 time units after a rising edge and
// outputs are compared 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_shift_sched;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shift_sched_if #(.WIDTH(4)) if_a ();
  shift_sched_if #(.WIDTH(4)) if_b ();

  logic a_x, a_frame, a_src, a_busy, a_done;
  logic b_x, b_frame, b_src, b_busy, b_done;

  shift_sched #(.WIDTH(4), .GAP(1)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .req_if  (if_a),
    .x_o     (a_x),
    .frame_o (a_frame),
    .src_o   (a_src),
    .busy_o  (a_busy),
    .done_o  (a_done)
  );

  shift_sched #(.WIDTH(4), .GAP(0)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .req_if  (if_b),
    .x_o     (b_x),
    .frame_o (b_frame),
    .src_o   (b_src),
    .busy_o  (b_busy),
    .done_o  (b_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Entered in the first frame cycle (N+1) of dut_a; returns in its next IDLE
  // cycle (N+6). Ready must stay low throughout even if a requester is valid.
  task automatic run_frame_a(input logic [3:0] word, input logic src);
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("a_frame",  a_frame, 1);
      check("a_x",      a_x, word[4-k]);
      check("a_src",    a_src, src);
      check("a_done",   a_done, (k == 4));
      check("a_busy",   a_busy, 1);
      check("a_ready0", if_a.req0_ready_o, 0);
      check("a_ready1", if_a.req1_ready_o, 0);
      next_cycle();
    end
    #1;
    check("a_gap_frame",  a_frame, 0);
    check("a_gap_x",      a_x, 0);
    check("a_gap_done",   a_done, 0);
    check("a_gap_busy",   a_busy, 1);
    check("a_gap_src",    a_src, src);
    check("a_gap_ready0", if_a.req0_ready_o, 0);
    check("a_gap_ready1", if_a.req1_ready_o, 0);
    next_cycle();
  endtask

  // Same for dut_b, which has no gap: returns in cycle N+5.
  task automatic run_frame_b(input logic [3:0] word, input logic src);
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("b_frame",  b_frame, 1);
      check("b_x",      b_x, word[4-k]);
      check("b_src",    b_src, src);
      check("b_done",   b_done, (k == 4));
      check("b_ready0", if_b.req0_ready_o, 0);
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    if_a.req0_valid_i = 1'b0; if_a.req0_data_i = 4'h0;
    if_a.req1_valid_i = 1'b0; if_a.req1_data_i = 4'h0;
    if_b.req0_valid_i = 1'b0; if_b.req0_data_i = 4'h0;
    if_b.req1_valid_i = 1'b0; if_b.req1_data_i = 4'h0;

    // Reset values.
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check("rst_x",      a_x, 0);
    check("rst_frame",  a_frame, 0);
    check("rst_done",   a_done, 0);
    check("rst_busy",   a_busy, 0);
    check("rst_src",    a_src, 0);
    check("rst_ready0", if_a.req0_ready_o, 0);
    check("rst_ready1", if_a.req1_ready_o, 0);
    check("rst_b_busy", b_busy, 0);
    next_cycle();

    // Single frame: req0 sends 1011.
    if_a.req0_valid_i = 1'b1; if_a.req0_data_i = 4'b1011;
    #1;
    check("single_ready0", if_a.req0_ready_o, 1);
    check("single_ready1", if_a.req1_ready_o, 0);
    check("single_busy",   a_busy, 0);
    next_cycle();
    if_a.req0_valid_i = 1'b0;
    run_frame_a(4'b1011, 1'b0);
    #1;
    check("single_idle_busy", a_busy, 0);
    next_cycle();

    // Contention from a fresh reset: strict 0,1,0,1 alternation.
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    if_a.req0_valid_i = 1'b1; if_a.req0_data_i = 4'hA;
    if_a.req1_valid_i = 1'b1; if_a.req1_data_i = 4'h5;
    for (int f = 0; f < 4; f++) begin
      #1;
      check("tie_ready0", if_a.req0_ready_o, (f % 2 == 0));
      check("tie_ready1", if_a.req1_ready_o, (f % 2 == 1));
      next_cycle();
      run_frame_a((f % 2 == 0) ? 4'hA : 4'h5, (f % 2 == 1));
    end
    if_a.req0_valid_i = 1'b0;
    if_a.req1_valid_i = 1'b0;

    // Late request: req1 rises during req0's frame, served at the next IDLE.
    if_a.req0_valid_i = 1'b1; if_a.req0_data_i = 4'hC;
    #1;
    check("late_ready0", if_a.req0_ready_o, 1);
    next_cycle();
    if_a.req0_valid_i = 1'b0;
    if_a.req1_valid_i = 1'b1; if_a.req1_data_i = 4'h6;
    run_frame_a(4'hC, 1'b0);
    #1;
    check("late_ready1", if_a.req1_ready_o, 1);
    next_cycle();
    if_a.req1_valid_i = 1'b0;
    run_frame_a(4'h6, 1'b1);

    // Reset after two bits of 1111 from req0 (leaves last = 0 if not cleared).
    if_a.req0_valid_i = 1'b1; if_a.req0_data_i = 4'hF;
    #1;
    check("mid_ready0", if_a.req0_ready_o, 1);
    next_cycle();
    if_a.req0_valid_i = 1'b0;
    #1;
    check("mid_bit1_x", a_x, 1);
    next_cycle();
    #1;
    check("mid_bit2_x", a_x, 1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check("mid_rst_frame", a_frame, 0);
    check("mid_rst_x",     a_x, 0);
    check("mid_rst_done",  a_done, 0);
    check("mid_rst_busy",  a_busy, 0);
    check("mid_rst_src",   a_src, 0);
    next_cycle();
    #1;
    check("mid_after_done",  a_done, 0);
    check("mid_after_frame", a_frame, 0);
    if_a.req0_valid_i = 1'b1; if_a.req0_data_i = 4'h9;
    if_a.req1_valid_i = 1'b1; if_a.req1_data_i = 4'h3;
    #1;
    check("mid_tie_ready0", if_a.req0_ready_o, 1);
    check("mid_tie_ready1", if_a.req1_ready_o, 0);
    next_cycle();
    if_a.req0_valid_i = 1'b0;
    run_frame_a(4'h9, 1'b0);
    #1;
    check("mid_tie2_ready1", if_a.req1_ready_o, 1);
    next_cycle();
    if_a.req1_valid_i = 1'b0;
    run_frame_a(4'h3, 1'b1);

    // GAP=0 build: continuous req0 stream, 5-cycle period.
    if_b.req0_valid_i = 1'b1; if_b.req0_data_i = 4'h9;
    #1;
    check("g0_ready0_first", if_b.req0_ready_o, 1);
    next_cycle();
    if_b.req0_data_i = 4'h6;
    run_frame_b(4'h9, 1'b0);
    #1;
    check("g0_idle1_frame",  b_frame, 0);
    check("g0_idle1_busy",   b_busy, 0);
    check("g0_idle1_ready0", if_b.req0_ready_o, 1);
    next_cycle();
    if_b.req0_data_i = 4'hE;
    run_frame_b(4'h6, 1'b0);
    #1;
    check("g0_idle2_frame",  b_frame, 0);
    check("g0_idle2_ready0", if_b.req0_ready_o, 1);
    next_cycle();
    if_b.req0_valid_i = 1'b0;
    run_frame_b(4'hE, 1'b0);
    #1;
    check("g0_end_frame",  b_frame, 0);
    check("g0_end_busy",   b_busy, 0);
    check("g0_end_ready0", if_b.req0_ready_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
